// File: rtl/capture_data_tx_n_v_pkg.sv
// Shared types and sizing for the TX capture path into BRAM.
// Holds the capture FSM encoding and the default word and address widths.
package capture_data_tx_n_v_pkg;

  localparam int CAP_DATA_W = 32;
  localparam int CAP_ADDR_W = 12;

  localparam logic ONE  = 1'b1;
  localparam logic NULL = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    CAPTURE,
    FLUSH,
    DONE
  } cap_state_t;

endpackage

// File: rtl/capture_data_tx_n_v_packer.sv
// Per-channel LSB-first serial-to-word packer with a one-word holding slot.
// Optional CAPTURE_FRAME_ALIGN_EN: later start bits cut the partial word so frames start at bit 0.
module cap_bit_packer
  import capture_data_tx_n_v_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W
) (
  input  logic              clk_15_o,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              flush,
  input  logic              full,
  input  logic              ce,
  input  logic              start,
  input  logic              data,
  input  logic              grant,
  output logic              armed,
  output logic              req,
  output logic              ovf,
  output logic [DATA_W-1:0] word
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] word_now;
  logic [CNT_W-1:0]  cnt;
  logic              pending;
  logic              fire;
  logic              arm_fire;
  logic              complete;
  logic              cut;
  logic              done;

  assign fire     = en && ce && !full;
  assign arm_fire = fire && start && !armed;
  assign complete = fire && armed && (cnt == CNT_W'(DATA_W - 1));

`ifdef CAPTURE_FRAME_ALIGN_EN
  assign cut = fire && armed && start && (cnt != '0);
`else
  assign cut = NULL;
`endif

  assign done     = cut || complete;
  assign word_now = cut ? sr : {data, sr[DATA_W-2:0]};
  assign ovf      = done && pending;

  // A finished word is offered the same cycle it completes; the slot only fills if the port is taken.
  assign req  = !full && (pending || done || (flush && (cnt != '0)));
  assign word = pending ? hold : (done ? word_now : sr);

  always_ff @(posedge clk_15_o or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      hold    <= '0;
      cnt     <= '0;
      pending <= NULL;
      armed   <= NULL;
    end else if (clr) begin
      sr      <= '0;
      hold    <= '0;
      cnt     <= '0;
      pending <= NULL;
      armed   <= NULL;
    end else begin
      if (done && !pending && !grant) begin
        pending <= ONE;
        hold    <= word_now;
      end else if (grant && pending) begin
        pending <= NULL;
      end

      if (arm_fire) begin
        armed <= ONE;
        sr    <= {{(DATA_W-1){1'b0}}, data};
        cnt   <= CNT_W'(1);
      end else if (cut) begin
        sr  <= {{(DATA_W-1){1'b0}}, data};
        cnt <= CNT_W'(1);
      end else if (complete) begin
        sr  <= '0;
        cnt <= '0;
      end else if (fire && armed) begin
        sr[cnt] <= data;
        cnt     <= cnt + CNT_W'(1);
      end else if (flush && grant && !pending) begin
        sr  <= '0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/capture_data_tx_n_v.sv
// Captures VSK/NSK coder bit streams into BRAM port A: VSK in the lower half, NSK in the upper half.
// Build option CAPTURE_FRAME_ALIGN_EN word-aligns every frame start (see cap_bit_packer).
module capture_data_tx_n_v
  import capture_data_tx_n_v_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W,
  parameter int ADDR_W = CAP_ADDR_W
) (
  input  logic              clk_15_o,
  input  logic              rst,
  input  logic              data_std,
  input  logic              cap_start,
  input  logic              cap_stop,
  input  logic              cod_ce_v_in,
  input  logic              cod_start_v_in,
  input  logic              cod_data_v_in,
  input  logic              cod_ce_n_in,
  input  logic              cod_start_n_in,
  input  logic              cod_data_n_in,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic [ADDR_W-1:0] words_v,
  output logic [ADDR_W-1:0] words_n,
  output logic              busy,
  output logic              end_data,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] HALF = ADDR_W'(1) << (ADDR_W - 1);

  cap_state_t        state;
  cap_state_t        state_nxt;
  logic              run_clr;
  logic              en;
  logic              flush;
  logic              full_v;
  logic              full_n;
  logic              armed_v;
  logic              armed_n;
  logic              req_v;
  logic              req_n;
  logic              ovf_v;
  logic              ovf_n;
  logic              grant_v;
  logic              grant_n;
  logic [DATA_W-1:0] word_v;
  logic [DATA_W-1:0] word_n;

  assign run_clr = (state == IDLE) && cap_start && data_std;
  assign en      = (state == ARM) || (state == CAPTURE);
  assign flush   = (state == FLUSH);
  assign full_v  = (words_v == HALF);
  assign full_n  = (words_n == HALF);

  // VSK always wins the shared port; NSK waits at most one cycle in its holding slot.
  assign grant_v = req_v;
  assign grant_n = req_n && !req_v;

  cap_bit_packer #(.DATA_W(DATA_W)) u_pack_v (
    .clk_15_o (clk_15_o),
    .rst      (rst),
    .clr      (run_clr),
    .en       (en),
    .flush    (flush),
    .full     (full_v),
    .ce       (cod_ce_v_in),
    .start    (cod_start_v_in),
    .data     (cod_data_v_in),
    .grant    (grant_v),
    .armed    (armed_v),
    .req      (req_v),
    .ovf      (ovf_v),
    .word     (word_v)
  );

  cap_bit_packer #(.DATA_W(DATA_W)) u_pack_n (
    .clk_15_o (clk_15_o),
    .rst      (rst),
    .clr      (run_clr),
    .en       (en),
    .flush    (flush),
    .full     (full_n),
    .ce       (cod_ce_n_in),
    .start    (cod_start_n_in),
    .data     (cod_data_n_in),
    .grant    (grant_n),
    .armed    (armed_n),
    .req      (req_n),
    .ovf      (ovf_n),
    .word     (word_n)
  );

  always_ff @(posedge clk_15_o or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cap_start && data_std) state_nxt = ARM;
      ARM: begin
        if (cap_stop || !data_std)       state_nxt = FLUSH;
        else if (armed_v || armed_n)     state_nxt = CAPTURE;
      end
      CAPTURE: if (cap_stop || !data_std || (full_v && full_n)) state_nxt = FLUSH;
      FLUSH:   if (!req_v && !req_n) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_15_o or posedge rst) begin
    if (rst) begin
      bram_en   <= NULL;
      bram_we   <= NULL;
      bram_addr <= '0;
      bram_din  <= '0;
      words_v   <= '0;
      words_n   <= '0;
      busy      <= NULL;
      end_data  <= NULL;
      overflow  <= NULL;
    end else begin
      bram_en <= grant_v || grant_n;
      bram_we <= grant_v || grant_n;
      if (grant_v) begin
        bram_addr <= {1'b0, words_v[ADDR_W-2:0]};
        bram_din  <= word_v;
      end else if (grant_n) begin
        bram_addr <= {1'b1, words_n[ADDR_W-2:0]};
        bram_din  <= word_n;
      end

      if (run_clr) begin
        words_v  <= '0;
        words_n  <= '0;
        overflow <= NULL;
      end else begin
        if (grant_v)       words_v  <= words_v + ADDR_W'(1);
        if (grant_n)       words_n  <= words_n + ADDR_W'(1);
        if (ovf_v || ovf_n) overflow <= ONE;
      end

      busy     <= (state_nxt == ARM) || (state_nxt == CAPTURE) || (state_nxt == FLUSH);
      end_data <= (state_nxt == DONE);
    end
  end

endmodule
